// File: rtl/serial_receiver.sv
// serial_receiver: asynchronous serial byte receiver feeding a small receive FIFO.
// Frame: start bit 0, 8 data bits LSB first, optional even-parity bit, stop bit 1.
// Define RX_PARITY_EN to compile in the parity bit, the PARITY state and parity_err.
// Without it the frame is 10 bits and parity_err is tied low.
module serial_receiver #(
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       re,
    output logic [7:0] data_out,
    output logic       empty,
    output logic       full,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overflow,
    output logic [2:0] state_dbg
);
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_HALF  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic [7:0]     shift, shift_n;
    logic           rx_q;
    logic           fe_n;
    logic           byte_ok;
    logic           sample;
    logic           bit_end;
`ifdef RX_PARITY_EN
    logic           par_bad, par_bad_n;
    logic           pe_n;
`endif

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wptr, rptr;
    logic [CNTW-1:0] count;
    logic            rd_en, wr_en;

    // IDLE detects the start edge on the raw line; every bit sample is taken from
    // rx_q, so the value captured at the sample cycle of a bit (counted from the
    // detection edge) is acted on one edge later. This lets START exist even when
    // a bit lasts a single clock.
    assign sample    = (cnt == CNT_HALF);
    assign bit_end   = (cnt == CNT_LAST);
    assign state_dbg = state;

    // Receiver state, bit timing, shift register and error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            rx_q      <= 1'b1;
            frame_err <= 1'b0;
`ifdef RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            rx_q      <= rx;
            frame_err <= fe_n;
`ifdef RX_PARITY_EN
            par_bad    <= par_bad_n;
            parity_err <= pe_n;
`endif
        end
    end

`ifndef RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Next-state logic: one state per bit period, sampling at the mid-bit count.
    always_comb begin
        state_n   = state;
        cnt_n     = bit_end ? '0 : cnt + 1'b1;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        fe_n      = 1'b0;
        byte_ok   = 1'b0;
`ifdef RX_PARITY_EN
        par_bad_n = par_bad;
        pe_n      = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n     = '0;
                bit_cnt_n = 3'd0;
`ifdef RX_PARITY_EN
                par_bad_n = 1'b0;
`endif
                if (!rx) state_n = START;
            end
            START: begin
                // A line that is high again at mid start bit was a glitch.
                if (sample && rx_q) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (bit_end) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (sample) shift_n = {rx_q, shift[7:1]};
                if (bit_end) begin
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                // Even parity: data bits plus parity bit must XOR to zero.
                if (sample) par_bad_n = rx_q ^ (^shift);
                if (bit_end) state_n = STOP;
            end
`endif
            STOP: begin
                if (sample) begin
                    cnt_n   = '0;
                    state_n = rx_q ? IDLE : WAIT_IDLE;
`ifdef RX_PARITY_EN
                    if (par_bad) begin
                        pe_n = 1'b1;
                    end else
`endif
                    if (rx_q) begin
                        byte_ok = 1'b1;
                    end else begin
                        fe_n = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                // Line break lockout: no new frame until the line has been high.
                cnt_n = '0;
                if (rx_q) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Read handshake: re is a request that is accepted only while !empty; the
    // popped byte is on data_out after that edge. A received byte is taken when
    // there is room, or when a read frees a slot on the same edge.
    assign rd_en = re && !empty;
    assign wr_en = byte_ok && (!full || rd_en);
    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    // FIFO storage, written without reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= shift;
    end

    // FIFO pointers, occupancy, read data and overflow pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            data_out <= 8'h00;
            overflow <= 1'b0;
        end else begin
            overflow <= byte_ok && full && !rd_en;
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) begin
                rptr     <= rptr + 1'b1;
                data_out <= mem[rptr];
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: two instances (1 and 4 clocks per bit), a frame-level
// reference model (byte queues plus scheduled frame outcomes), one compare process
// checking every output on every cycle, and literal checks for the directed cases.
module tb_serial_receiver;
    localparam int DEPTH = 8;
`ifdef RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int K_GOOD  = 0;
    localparam int K_FRAME = 1;
    localparam int K_PAR   = 2;

    typedef struct {
        int         inst;
        int         cyc;
        int         kind;
        logic [7:0] b;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rx;
    logic [1:0] re;
    logic [7:0] dout [2];
    logic [1:0] empty, full, fe, pe, ov;
    logic [2:0] dbg [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        serial_receiver #(.CLKS_PER_BIT(g == 0 ? 1 : 4), .FIFO_DEPTH(DEPTH)) dut (
            .clk(clk), .rst(rst), .rx(rx[g]), .re(re[g]),
            .data_out(dout[g]), .empty(empty[g]), .full(full[g]),
            .frame_err(fe[g]), .parity_err(pe[g]), .overflow(ov[g]),
            .state_dbg(dbg[g])
        );
    end

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    ev_t        ev_q[$];
    logic [7:0] exp_dout [2] = '{8'h00, 8'h00};
    logic       exp_fe [2] = '{1'b0, 1'b0};
    logic       exp_pe [2] = '{1'b0, 1'b0};
    logic       exp_ov [2] = '{1'b0, 1'b0};
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         fe_seen [2] = '{0, 0};
    int         pe_seen [2] = '{0, 0};
    int         ov_seen [2] = '{0, 0};
    logic       m_wr, m_rd;
    logic [7:0] m_b;
    int         t0, base0, base1, base2, done_cnt, rand_start;

    function automatic int cpb_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [7:0] qpop(input int i);
        if (i == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    task automatic qpush(input int i, input logic [7:0] b);
        if (i == 0) exp_q0.push_back(b);
        else exp_q1.push_back(b);
    endtask

    task automatic chk(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h state=%0d", name, i, cyc, act, exp, dbg[i]);
        end
    endtask

    // Model update on each active edge: frame outcomes scheduled by the driver,
    // reads accepted when the model queue is non-empty, drops when full.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            exp_q0.delete();
            exp_q1.delete();
            ev_q.delete();
            for (int i = 0; i < 2; i++) begin
                exp_dout[i] = 8'h00;
                exp_fe[i] = 1'b0;
                exp_pe[i] = 1'b0;
                exp_ov[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_wr = 1'b0;
                m_b = 8'h00;
                exp_fe[i] = 1'b0;
                exp_pe[i] = 1'b0;
                exp_ov[i] = 1'b0;
                foreach (ev_q[k]) begin
                    if (ev_q[k].inst == i && ev_q[k].cyc == cyc) begin
                        if (ev_q[k].kind == K_GOOD) begin
                            m_wr = 1'b1;
                            m_b = ev_q[k].b;
                        end else if (ev_q[k].kind == K_FRAME) begin
                            exp_fe[i] = 1'b1;
                        end else begin
                            exp_pe[i] = 1'b1;
                        end
                    end
                end
                m_rd = re[i] && (qsize(i) != 0);
                if (m_rd) exp_dout[i] = qpop(i);
                if (m_wr) begin
                    if (qsize(i) == DEPTH) exp_ov[i] = 1'b1;
                    else qpush(i, m_b);
                end
            end
            for (int k = ev_q.size() - 1; k >= 0; k--)
                if (ev_q[k].cyc <= cyc) ev_q.delete(k);
        end
    end

    // Compare process: all outputs of both instances, every cycle, away from the edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("empty", i, {7'd0, empty[i]}, {7'd0, qsize(i) == 0});
            chk("full", i, {7'd0, full[i]}, {7'd0, qsize(i) == DEPTH});
            chk("data_out", i, dout[i], exp_dout[i]);
            chk("frame_err", i, {7'd0, fe[i]}, {7'd0, exp_fe[i]});
            chk("parity_err", i, {7'd0, pe[i]}, {7'd0, exp_pe[i]});
            chk("overflow", i, {7'd0, ov[i]}, {7'd0, exp_ov[i]});
            fe_seen[i] += int'(fe[i]);
            pe_seen[i] += int'(pe[i]);
            ov_seen[i] += int'(ov[i]);
        end
    end

    // Drive one frame on instance i and schedule its outcome at the stop-sample decision edge.
    task automatic send_frame(input int i, input logic [7:0] b, input logic stop_v,
                              input logic par_flip, input int low_after, input int gap);
        int c;
        int e0;
        int d;
        int kind;
        logic par_ok;
        logic [NB-1:0] bits;
        c = cpb_of(i);
        bits = '0;
        bits[8:1] = b;
`ifdef RX_PARITY_EN
        bits[9] = (^b) ^ par_flip;
        par_ok = !par_flip;
`else
        par_ok = 1'b1;
        if (par_flip) par_ok = 1'b1;
`endif
        bits[NB-1] = stop_v;
        @(negedge clk);
        rx[i] = 1'b0;
        e0 = cyc + 1;
        d = e0 + 1 + (NB - 1) * c + c / 2;
        kind = !par_ok ? K_PAR : (stop_v ? K_GOOD : K_FRAME);
        ev_q.push_back('{i, d, kind, b});
        repeat (c - 1) @(negedge clk);
        for (int k = 1; k < NB; k++) begin
            repeat (c) begin
                @(negedge clk);
                rx[i] = bits[k];
            end
        end
        repeat (low_after) begin
            @(negedge clk);
            rx[i] = 1'b0;
        end
        @(negedge clk);
        rx[i] = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_read(input int i);
        @(negedge clk);
        re[i] = 1'b1;
        @(negedge clk);
        re[i] = 1'b0;
    endtask

    task automatic rand_frames(input int i, input int n);
        logic [7:0] b;
        logic stop_v;
        for (int k = 0; k < n; k++) begin
            b = 8'($urandom_range(0, 255));
            stop_v = ($urandom_range(0, 9) != 0);
            send_frame(i, b, stop_v, $urandom_range(0, 7) == 0,
                       stop_v ? 0 : $urandom_range(0, 4), $urandom_range(2, 6));
        end
        done_cnt++;
    endtask

    initial begin
        rst = 1'b0;
        rx = 2'b11;
        re = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_empty", 0, {7'd0, empty[0]}, 8'd1);
        chk("rst_full", 1, {7'd0, full[1]}, 8'd0);
        chk("rst_dout", 0, dout[0], 8'h00);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);

        // A5 at one clock per bit: empty falls one cycle after the stop sample.
        fork
            send_frame(0, 8'hA5, 1'b1, 1'b0, 0, 3);
            begin
                @(negedge clk);
                t0 = cyc + 1;
                for (int k = 0; k < 40 && cyc < t0 + 9; k++) @(negedge clk);
                chk("a5_empty_at_stop", 0, {7'd0, empty[0]}, 8'd1);
                @(negedge clk);
                chk("a5_empty_after", 0, {7'd0, empty[0]}, 8'd0);
            end
        join
        do_read(0);
        chk("a5_read", 0, dout[0], 8'hA5);
        chk("a5_empty_end", 0, {7'd0, empty[0]}, 8'd1);

        // Nine bytes into an eight-entry FIFO with no reads.
        base0 = ov_seen[0];
        for (int k = 1; k <= 9; k++) begin
            send_frame(0, 8'(k), 1'b1, 1'b0, 0, 2);
            if (k == 8) chk("fill_full", 0, {7'd0, full[0]}, 8'd1);
        end
        chk("fill_ovf_once", 0, 8'(ov_seen[0] - base0), 8'd1);
        chk("fill_still_full", 0, {7'd0, full[0]}, 8'd1);
        for (int k = 1; k <= 8; k++) begin
            do_read(0);
            chk("fill_read", 0, dout[0], 8'(k));
        end
        chk("fill_empty", 0, {7'd0, empty[0]}, 8'd1);

        // Bad stop bit followed by a held-low line.
        base0 = fe_seen[0];
        send_frame(0, 8'h3C, 1'b0, 1'b0, 5, 3);
        chk("brk_fe_once", 0, 8'(fe_seen[0] - base0), 8'd1);
        chk("brk_empty", 0, {7'd0, empty[0]}, 8'd1);
        send_frame(0, 8'h5A, 1'b1, 1'b0, 0, 3);
        do_read(0);
        chk("brk_recover", 0, dout[0], 8'h5A);

        // One-cycle glitch at four clocks per bit.
        base0 = fe_seen[1];
        base1 = pe_seen[1];
        base2 = ov_seen[1];
        @(negedge clk);
        rx[1] = 1'b0;
        @(negedge clk);
        rx[1] = 1'b1;
        repeat (8) @(negedge clk);
        chk("glitch_empty", 1, {7'd0, empty[1]}, 8'd1);
        chk("glitch_no_err", 1, 8'((fe_seen[1] - base0) + (pe_seen[1] - base1) + (ov_seen[1] - base2)), 8'd0);
        send_frame(1, 8'hC3, 1'b1, 1'b0, 0, 3);
        do_read(1);
        chk("glitch_recover", 1, dout[1], 8'hC3);

`ifdef RX_PARITY_EN
        send_frame(0, 8'h07, 1'b1, 1'b0, 0, 3);
        do_read(0);
        chk("par_good", 0, dout[0], 8'h07);
        base0 = pe_seen[0];
        send_frame(0, 8'h07, 1'b1, 1'b1, 0, 3);
        chk("par_bad_pulse", 0, 8'(pe_seen[0] - base0), 8'd1);
        chk("par_bad_empty", 0, {7'd0, empty[0]}, 8'd1);
`endif

        // Reset mid-frame with a byte already queued.
        send_frame(0, 8'h99, 1'b1, 1'b0, 0, 3);
        @(negedge clk);
        rx[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            rx[0] = 1'b1;
        end
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_empty", 0, {7'd0, empty[0]}, 8'd1);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(0, 8'h42, 1'b1, 1'b0, 0, 3);
        chk("mid_rst_dout0", 0, dout[0], 8'h00);
        do_read(0);
        chk("mid_rst_read", 0, dout[0], 8'h42);
        chk("mid_rst_end", 0, {7'd0, empty[0]}, 8'd1);

        // Random frames on both instances with random reads.
        done_cnt = 0;
        rand_start = cyc;
        fork
            rand_frames(0, 30);
            rand_frames(1, 20);
            begin
                while (done_cnt < 2 && cyc < rand_start + 20000) begin
                    @(negedge clk);
                    re[0] = ($urandom_range(0, (cyc < rand_start + 400) ? 60 : 4) == 0);
                    re[1] = ($urandom_range(0, (cyc < rand_start + 900) ? 200 : 12) == 0);
                end
                @(negedge clk);
                re = 2'b00;
            end
        join
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < DEPTH + 2 && !empty[i]; k++) do_read(i);
        chk("drain_empty0", 0, {7'd0, empty[0]}, 8'd1);
        chk("drain_empty1", 1, {7'd0, empty[1]}, 8'd1);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 1, clock cycles per serial bit (integer >= 1).
REQ-002 Parameter: FIFO_DEPTH, default 8, receive FIFO entries (power of 2, >= 2).
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: rx  input  1  serial line; idle high.
REQ-006 Port: re  input  1  FIFO read enable.
REQ-007 Port: data_out  output  8  byte popped by last accepted read (registered).
REQ-008 Port: empty  output  1  FIFO holds no bytes.
REQ-009 Port: full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-010 Port: frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 Port: parity_err  output  1  one-cycle pulse: parity mismatch (see Configuration).
REQ-012 Port: overflow  output  1  one-cycle pulse: good byte dropped because FIFO full.

Function
REQ-013 Frame SHALL be: start bit 0, 8 data bits LSB first, [parity bit], stop bit 1.
REQ-014 Each bit SHALL be sampled once, at cycle CLKS_PER_BIT/2 (integer division) of its bit period, counted from detection of rx==0 in IDLE.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-016 IDLE -> START when rx==0; START -> DATA if start sample is 0, else -> IDLE (glitch rejection).
REQ-017 DATA SHALL shift in 8 samples via a 3-bit bit counter, then -> PARITY (if compiled in) or STOP.
REQ-018 STOP sample 1 -> IDLE with byte valid; STOP sample 0 -> frame_err pulse, byte discarded, -> WAIT_IDLE.
REQ-019 WAIT_IDLE -> IDLE only after rx sampled 1 (line-break lockout).
REQ-020 A valid byte SHALL be written into the FIFO on the clock edge following the stop-bit sample; empty deasserts that same edge.
REQ-021 re && !empty: data_out SHALL take head byte on next edge; read pointer advances; re while empty SHALL be ignored, data_out held.
REQ-022 Byte written while full and no simultaneous read: dropped, overflow pulses, FIFO contents unchanged.
REQ-023 Write and read on same edge while full: both accepted, full stays 1, no overflow.
REQ-024 Write and read on same edge while empty: write accepted, read ignored.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.
REQ-026 Error pulses SHALL be mutually exclusive per frame; priority parity_err over frame_err (byte dropped either way).

Reset
REQ-027 rst low SHALL immediately force: FSM IDLE, counters 0, pointers 0, data_out 8'h00, empty 1, full 0, all pulses 0.
REQ-028 Reset mid-frame SHALL abandon the partial byte; after release receiver SHALL resynchronize on the next rx==0.
REQ-029 FIFO storage array need not be reset.

Configuration
REQ-030 Macro RX_PARITY_EN: defined -> PARITY state present, one even-parity bit after data; mismatch pulses parity_err at stop-bit sample, byte discarded, FSM proceeds through STOP normally.
REQ-031 RX_PARITY_EN undefined -> no PARITY state, 10-bit frame, parity_err tied 0.

Verification
REQ-032 CLKS_PER_BIT=1, no parity: send 8'hA5 (rx: 0,1,0,1,0,0,1,0,1,1) -> empty falls one cycle after stop sample; re -> data_out=8'hA5, empty=1.
REQ-033 Send 9 bytes 8'h01..8'h09 with FIFO_DEPTH=8, no reads -> full=1 after 8th; overflow pulses once on 9th; reads return 8'h01..8'h08.
REQ-034 Send 8'h3C with stop bit 0, then hold rx low 5 cycles -> frame_err one pulse, empty stays 1, no new frame until rx high.
REQ-035 One-cycle rx low glitch with CLKS_PER_BIT=4 (rx high at sample) -> FSM returns IDLE, no FIFO write, no error pulse.
REQ-036 RX_PARITY_EN defined: 8'h07 with parity 1 -> stored; with parity 0 -> parity_err pulse, empty stays 1.
REQ-037 Assert rst low after 4th data bit of 8'hFF, release, send 8'h42 -> only 8'h42 read back, data_out=8'h00 before first read.
